slot_feeder: RTL and testbench

- Fixed-cadence stage that sits directly upstream of the tainted-data consumer. It supplies that consumer's secret word `x` and its public mode flag `slow`.
- Buffers incoming (data, slow) pairs in a small FIFO and releases at most one entry per fixed slot of PERIOD cycles.
- Release timing depends only on public state (slot counter, FIFO occupancy), never on data values. This keeps the stage constant-time under the information-flow checker.
- Data is a taint source and flows straight through; `slow` is a public (sanitized) control bit.

---
 rtl/slot_feeder_pkg.sv | 21 ++
 rtl/slot_fifo.sv | 57 +++++
 rtl/slot_feeder.sv | 110 +++++++++++
 tb/tb_slot_feeder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/slot_feeder_pkg.sv
// Shared defaults, derived widths and the queued entry layout for the slot feeder.
package slot_feeder_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_DEPTH  = 4;
  localparam int DEF_PERIOD = 4;

  localparam int PTR_W = $clog2(DEF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic                 slow;
    logic [DEF_WIDTH-1:0] data;
  } entry_t;

  // Index width for a power-of-two depth or a counter range; never below one bit.
  function automatic int ptr_bits(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/slot_fifo.sv
// Plain synchronous FIFO: combinational read of the head entry, no output register.
module slot_fifo
  import slot_feeder_pkg::*;
#(
  parameter  int EW    = DEF_WIDTH + 1,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int PW    = ptr_bits(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [EW-1:0] i_wdata,
  output logic [EW-1:0] o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  logic [EW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/slot_feeder.sv
// Releases at most one buffered (data, slow) entry per fixed slot; release timing
// depends only on the slot counter and occupancy, never on data values.
module slot_feeder
  import slot_feeder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int PERIOD = DEF_PERIOD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_slow,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_x,
  output logic             out_slow,
  output logic [7:0]       drop_cnt
);

  localparam int SW = ptr_bits(PERIOD);
  localparam int CW = ptr_bits(DEPTH) + 1;

  typedef struct packed {
    logic             slow;
    logic [WIDTH-1:0] data;
  } ent_t;

  logic [SW-1:0] r_slot;
  logic          r_out_valid;
  logic [WIDTH-1:0] r_out_x;
  logic          r_out_slow;
  logic [7:0]    r_drop_cnt;

  logic          w_tick;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  ent_t          w_wentry;
  ent_t          w_head;

  assign w_tick   = (r_slot == SW'(PERIOD - 1));
  assign in_ready = (w_count != CW'(DEPTH));
  assign w_push   = in_valid && in_ready;
  assign w_pop    = w_tick && !w_empty;

  assign w_wentry.slow = in_slow;
  assign w_wentry.data = in_data;

  slot_fifo #(
    .EW    (WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_wentry),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Free-running slot counter; runs regardless of occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot <= '0;
    end else if (w_tick) begin
      r_slot <= '0;
    end else begin
      r_slot <= r_slot + SW'(1);
    end
  end

  // Output is a one-cycle strobe; data lines are zeroed on every non-release
  // cycle so a released word never lingers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_x     <= '0;
      r_out_slow  <= 1'b0;
    end else if (w_pop) begin
      r_out_valid <= 1'b1;
      r_out_x     <= w_head.data;
      r_out_slow  <= w_head.slow;
    end else begin
      r_out_valid <= 1'b0;
      r_out_x     <= '0;
      r_out_slow  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if (in_valid && w_full && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign out_valid = r_out_valid;
  assign out_x     = r_out_x;
  assign out_slow  = r_out_slow;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_slot_feeder.sv
// Randomized and directed bench for slot_feeder against a queue-based slot model.
module tb_slot_feeder;
  import slot_feeder_pkg::*;

  localparam int W = 8;
  localparam int D = 4;
  localparam int P = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_slow;
  logic         out_valid;
  logic [W-1:0] out_x;
  logic         out_slow;
  logic [7:0]   drop_cnt;

  slot_feeder #(.WIDTH(W), .DEPTH(D), .PERIOD(P)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_slow   (in_slow),
    .out_valid (out_valid),
    .out_x     (out_x),
    .out_slow  (out_slow),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a queue of entries plus the slot position of the next edge.
  entry_t       mq[$];
  int           mcnt;
  int           mdrop;
  logic         e_valid;
  logic [W-1:0] e_x;
  logic         e_slow;
  int           rec_sel = 0;
  int           tr_a[$];
  int           tr_b[$];

  task automatic model_reset();
    mq.delete();
    mcnt    = 0;
    mdrop   = 0;
    e_valid = 1'b0;
    e_x     = '0;
    e_slow  = 1'b0;
  endtask

  // Drive one cycle's inputs, advance the model across the coming edge, check after it.
  task automatic step(input logic v, input logic [W-1:0] d, input logic s);
    entry_t e;
    bit     full_pre;
    in_valid = v;
    in_data  = d;
    in_slow  = s;
    chk("in_ready", in_ready, (mq.size() < D) ? 1 : 0);
    full_pre = (mq.size() == D);
    e_valid  = 1'b0;
    e_x      = '0;
    e_slow   = 1'b0;
    if (mcnt == P - 1 && mq.size() > 0) begin
      e       = mq.pop_front();
      e_valid = 1'b1;
      e_x     = e.data;
      e_slow  = e.slow;
    end
    if (v) begin
      if (full_pre) begin
        if (mdrop < 255) mdrop++;
      end else begin
        mq.push_back(entry_t'({s, d}));
      end
    end
    mcnt = (mcnt + 1) % P;
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, e_valid);
    chk("out_x", out_x, e_x);
    chk("out_slow", out_slow, e_slow);
    chk("drop_cnt", drop_cnt, mdrop);
    if (rec_sel == 1) tr_a.push_back({drop_cnt, in_ready, out_valid});
    if (rec_sel == 2) tr_b.push_back({drop_cnt, in_ready, out_valid});
  endtask

  task automatic wait_cnt(input int k);
    while (mcnt != k) step(1'b0, '0, 1'b0);
  endtask

  task automatic apply_reset();
    in_valid = 1'b0;
    in_data  = '0;
    in_slow  = 1'b0;
    rst      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_x", out_x, 0);
    chk("rst_out_slow", out_slow, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
  endtask

  logic pv [56];
  logic ps [56];

  initial begin
    rst = 1'b1;
    apply_reset();

    // Idle: no strobes, data lines stay zero.
    repeat (12) step(1'b0, '0, 1'b0);

    // Single word pushed at slot 1 emerges after the slot-3 tick.
    apply_reset();
    wait_cnt(1);
    step(1'b1, 8'hA5, 1'b1);
    step(1'b0, '0, 1'b0);
    chk("a5_early", out_valid, 0);
    step(1'b0, '0, 1'b0);
    chk("a5_valid", out_valid, 1);
    chk("a5_x", out_x, 8'hA5);
    chk("a5_slow", out_slow, 1);
    step(1'b0, '0, 1'b0);
    chk("a5_cleared", out_x, 0);

    // Push on the tick edge while empty waits a full slot.
    wait_cnt(3);
    step(1'b1, 8'h11, 1'b0);
    chk("t11_same_tick", out_valid, 0);
    repeat (3) step(1'b0, '0, 1'b0);
    chk("t11_not_yet", out_valid, 0);
    step(1'b0, '0, 1'b0);
    chk("t11_valid", out_valid, 1);
    chk("t11_x", out_x, 8'h11);

    // Fill to full starting on a tick edge, then overflow.
    apply_reset();
    wait_cnt(3);
    for (int i = 1; i <= 4; i++) step(1'b1, W'(i), i[0]);
    chk("full_ready", in_ready, 0);
    step(1'b1, 8'h05, 1'b0);
    chk("drop_after_5", drop_cnt, 1);
    step(1'b1, 8'h06, 1'b1);
    chk("drop_after_6", drop_cnt, 1);
    repeat (20) step(1'b0, '0, 1'b0);

    // Same control timing with all-zero vs all-one data must give identical traces.
    for (int i = 0; i < 56; i++) begin
      pv[i] = (i < 40) ? (($urandom % 4) != 0) : 1'b0;
      ps[i] = 1'($urandom);
    end
    rec_sel = 1;
    apply_reset();
    for (int i = 0; i < 56; i++) step(pv[i], 8'h00, ps[i]);
    rec_sel = 2;
    apply_reset();
    for (int i = 0; i < 56; i++) step(pv[i], 8'hFF, ps[i]);
    rec_sel = 0;
    chk("ct_len", tr_b.size(), tr_a.size());
    for (int i = 0; i < tr_a.size() && i < tr_b.size(); i++) chk("ct_trace", tr_b[i], tr_a[i]);

    // Asynchronous reset with three entries queued and a strobe pending.
    apply_reset();
    wait_cnt(0);
    step(1'b1, 8'h21, 1'b0);
    step(1'b1, 8'h22, 1'b1);
    step(1'b1, 8'h23, 1'b0);
    step(1'b1, 8'h24, 1'b1);
    chk("pre_rst_valid", out_valid, 1);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_x", out_x, 0);
    chk("async_rst_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    repeat (8) step(1'b0, '0, 1'b0);
    chk("post_rst_drop", drop_cnt, 0);

    // Sustained offering drives drop_cnt into saturation, then mixed traffic.
    apply_reset();
    repeat (600) step(1'b1, W'($urandom), 1'($urandom));
    chk("drop_saturated", drop_cnt, 255);
    repeat (300) step(($urandom % 3) == 0, W'($urandom), 1'($urandom));
    repeat (20) step(1'b0, '0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
